// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg
//   Shared definitions for the data-memory port arbiter and the data memory:
//   the arbiter FSM state encoding and the default data/address widths.
package dmem_port_arbiter_pkg;

  // Default geometry of the data memory. The arbiter uses these values as
  // its parameter defaults.
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_ADDR_WIDTH = 10;

  // Arbiter FSM state encoding.
  // ARB_IDLE   : normal operation; pass-through or first half of a conflict.
  // ARB_SECOND : second half of a conflict; lane 2 owns the port.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_SECOND = 1'b1
  } arbState_t;

endpackage : dmem_port_arbiter_pkg

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the two MEM-stage lanes of the
//   dual-issue pipeline. A lone access passes straight through. When both
//   lanes access memory in the same cycle, lane 1 goes first while stallMem
//   freezes the pipeline for one cycle; lane 2 goes in the following cycle,
//   and lane 1's load data is replayed from a holding register so both
//   results reach MEM/WB together.
//
// Configuration macro:
//   DMEM_ARB_LOAD_MERGE_EN - when defined, two loads to the same address in
//   the same cycle are served by a single access, with no stall.
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   memRead1/2, memWrite1/2      per-lane load/store requests
//   addr1/2, writeData1/2        per-lane word address and store data
//   killMem2                     lane 2 MEM instruction squashed
//   dmemReadData                 memory read data (combinational from dmemAddr)
//   dmemAddr, dmemWriteData      memory address and store data
//   dmemWE                       memory write enable (committed at clk edge)
//   readData1/2                  load results to the MEM/WB register
//   stallMem                     freeze PC..EX/MEM for this cycle
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memRead1,
  input  logic                  memWrite1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] writeData1,
  input  logic                  memRead2,
  input  logic                  memWrite2,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0] writeData2,
  input  logic                  killMem2,
  input  logic [DATA_WIDTH-1:0] dmemReadData,
  output logic [ADDR_WIDTH-1:0] dmemAddr,
  output logic [DATA_WIDTH-1:0] dmemWriteData,
  output logic                  dmemWE,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  stallMem
);

  arbState_t             stateReg;
  arbState_t             stateNext;
  logic [DATA_WIDTH-1:0] hold1Reg;
  logic [DATA_WIDTH-1:0] hold1Next;

  logic req1;
  logic req2;
  logic mergeHit;
  logic conflict;

  assign req1 = memRead1 | memWrite1;
  assign req2 = (memRead2 | memWrite2) & ~killMem2;

`ifdef DMEM_ARB_LOAD_MERGE_EN
  // Two pure loads of the same word need only one access: lane 1 drives the
  // port and both lanes see the same read data.
  assign mergeHit = memRead1 & memRead2 & ~memWrite1 & ~memWrite2 &
                    ~killMem2 & (addr1 == addr2);
`else
  assign mergeHit = 1'b0;
`endif

  assign conflict = req1 & req2 & ~mergeHit;

  // State and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= ARB_IDLE;
      hold1Reg <= '0;
    end else begin
      stateReg <= stateNext;
      hold1Reg <= hold1Next;
    end
  end

  // Next-state logic and port muxing.
  always_comb begin
    stateNext     = stateReg;
    hold1Next     = hold1Reg;
    dmemAddr      = addr1;
    dmemWriteData = writeData1;
    dmemWE        = 1'b0;
    readData1     = dmemReadData;
    readData2     = dmemReadData;
    stallMem      = 1'b0;

    unique case (stateReg)
      ARB_IDLE: begin
        if (req1) begin
          // Lane 1 owns the port whenever it requests, including the first
          // half of a conflict and a merged double load.
          dmemAddr      = addr1;
          dmemWriteData = writeData1;
          dmemWE        = memWrite1;
          if (conflict) begin
            stallMem  = 1'b1;
            hold1Next = dmemReadData;
            stateNext = ARB_SECOND;
          end
        end else if (req2) begin
          dmemAddr      = addr2;
          dmemWriteData = writeData2;
          dmemWE        = memWrite2;
        end
      end

      ARB_SECOND: begin
        // Lane inputs are frozen by the stall, so the live lane 2 inputs are
        // the ones that caused the conflict. A late kill drops the access.
        dmemAddr      = addr2;
        dmemWriteData = writeData2;
        dmemWE        = memWrite2 & req2;
        readData1     = hold1Reg;
        stateNext     = ARB_IDLE;
      end

      default: begin
        stateNext = ARB_IDLE;
      end
    endcase
  end

endmodule : dmem_port_arbiter

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed self-checking bench for dmem_port_arbiter. A behavioural word
//   memory sits on the arbiter's memory port; a backdoor write path preloads
//   it. One task per scenario, each with its own inline checks.
module tb_dmem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          memRead1, memWrite1, memRead2, memWrite2, killMem2;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] writeData1, writeData2;
  logic [DW-1:0] dmemReadData;
  logic [AW-1:0] dmemAddr;
  logic [DW-1:0] dmemWriteData;
  logic          dmemWE;
  logic [DW-1:0] readData1, readData2;
  logic          stallMem;

  // Memory model with a backdoor preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bdWe;
  logic [AW-1:0] bdAddr;
  logic [DW-1:0] bdData;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign dmemReadData = mem[dmemAddr];

  always @(posedge clk) begin
    if (dmemWE) mem[dmemAddr] <= dmemWriteData;
    else if (bdWe) mem[bdAddr] <= bdData;
  end

  dmem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .memRead1(memRead1), .memWrite1(memWrite1), .addr1(addr1), .writeData1(writeData1),
    .memRead2(memRead2), .memWrite2(memWrite2), .addr2(addr2), .writeData2(writeData2),
    .killMem2(killMem2), .dmemReadData(dmemReadData),
    .dmemAddr(dmemAddr), .dmemWriteData(dmemWriteData), .dmemWE(dmemWE),
    .readData1(readData1), .readData2(readData2), .stallMem(stallMem)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    memRead1 = 0; memWrite1 = 0; addr1 = '0; writeData1 = '0;
    memRead2 = 0; memWrite2 = 0; addr2 = '0; writeData2 = '0;
    killMem2 = 0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bdWe = 1; bdAddr = a; bdData = d;
    tick();
    bdWe = 0;
  endtask

  task automatic test_reset();
    reset = 1; bdWe = 0; bdAddr = '0; bdData = '0;
    idleInputs();
    tick();
    preload(10'd12, 32'hC3);
    preload(10'd5, 32'hAA);
    preload(10'd8, 32'h3C);
    preload(10'd3, 32'h11);
    preload(10'd7, 32'h22);
    preload(10'd4, 32'h00);
    preload(10'd10, 32'h5A);
    preload(10'd11, 32'h33);
    preload(10'd6, 32'h77);
    reset = 0;
    addr1 = 10'd12;
    #1;
    vectors++;
    if (stallMem !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %0b want 0", stallMem); end
    vectors++;
    if (dmemWE !== 1'b0) begin miscompares++; $display("FAIL reset_we got %0b want 0", dmemWE); end
    vectors++;
    if (dmemAddr !== 10'd12) begin miscompares++; $display("FAIL reset_addr got %0d want 12", dmemAddr); end
    vectors++;
    if (readData1 !== 32'hC3) begin miscompares++; $display("FAIL reset_rd1 got %h want c3", readData1); end
    $display("reset: stall=%0b we=%0b addr=%0d", stallMem, dmemWE, dmemAddr);
    tick();
  endtask

  task automatic test_single_lane1();
    idleInputs();
    memRead1 = 1; addr1 = 10'd5;
    #1;
    vectors++;
    if (readData1 !== 32'hAA) begin miscompares++; $display("FAIL l1_rd1 got %h want aa", readData1); end
    vectors++;
    if (stallMem !== 1'b0) begin miscompares++; $display("FAIL l1_stall got %0b want 0", stallMem); end
    vectors++;
    if (dmemAddr !== 10'd5) begin miscompares++; $display("FAIL l1_addr got %0d want 5", dmemAddr); end
    tick();
    // Still in IDLE: same single request, still no stall, same data.
    vectors++;
    if (stallMem !== 1'b0 || readData1 !== 32'hAA) begin
      miscompares++; $display("FAIL l1_repeat got stall=%0b rd1=%h want stall=0 rd1=aa", stallMem, readData1);
    end
    $display("lane1 load: addr=5 rd1=%h stall=%0b", readData1, stallMem);
    idleInputs();
    tick();
  endtask

  task automatic test_single_lane2();
    idleInputs();
    memRead2 = 1; addr2 = 10'd8;
    #1;
    vectors++;
    if (dmemAddr !== 10'd8 || readData2 !== 32'h3C || stallMem !== 1'b0) begin
      miscompares++; $display("FAIL l2_load got addr=%0d rd2=%h stall=%0b want addr=8 rd2=3c stall=0", dmemAddr, readData2, stallMem);
    end
    $display("lane2 load: addr=%0d rd2=%h", dmemAddr, readData2);
    tick();
    idleInputs();
    memWrite2 = 1; addr2 = 10'd8; writeData2 = 32'h4D;
    #1;
    vectors++;
    if (dmemWE !== 1'b1 || dmemWriteData !== 32'h4D || stallMem !== 1'b0) begin
      miscompares++; $display("FAIL l2_store got we=%0b wd=%h stall=%0b want we=1 wd=4d stall=0", dmemWE, dmemWriteData, stallMem);
    end
    tick();
    idleInputs();
    #1;
    vectors++;
    if (mem[8] !== 32'h4D) begin miscompares++; $display("FAIL l2_store_mem got %h want 4d", mem[8]); end
    $display("lane2 store: mem[8]=%h", mem[8]);
  endtask

  task automatic test_conflict_loads();
    idleInputs();
    memRead1 = 1; addr1 = 10'd3;
    memRead2 = 1; addr2 = 10'd7;
    #1;
    vectors++;
    if (stallMem !== 1'b1 || dmemAddr !== 10'd3) begin
      miscompares++; $display("FAIL cl_c0 got stall=%0b addr=%0d want stall=1 addr=3", stallMem, dmemAddr);
    end
    tick();
    vectors++;
    if (dmemAddr !== 10'd7 || readData1 !== 32'h11 || readData2 !== 32'h22 || stallMem !== 1'b0) begin
      miscompares++; $display("FAIL cl_c1 got addr=%0d rd1=%h rd2=%h stall=%0b want addr=7 rd1=11 rd2=22 stall=0", dmemAddr, readData1, readData2, stallMem);
    end
    $display("conflict loads: rd1=%h rd2=%h", readData1, readData2);
    idleInputs();
    tick();
  endtask

  task automatic test_store_then_load();
    idleInputs();
    memWrite1 = 1; addr1 = 10'd4; writeData1 = 32'h55;
    memRead2  = 1; addr2 = 10'd4;
    #1;
    vectors++;
    if (dmemWE !== 1'b1 || dmemWriteData !== 32'h55 || stallMem !== 1'b1) begin
      miscompares++; $display("FAIL sl_c0 got we=%0b wd=%h stall=%0b want we=1 wd=55 stall=1", dmemWE, dmemWriteData, stallMem);
    end
    tick();
    vectors++;
    if (readData2 !== 32'h55 || dmemWE !== 1'b0) begin
      miscompares++; $display("FAIL sl_c1 got rd2=%h we=%0b want rd2=55 we=0", readData2, dmemWE);
    end
    $display("store->load addr4: rd2=%h", readData2);
    idleInputs();
    tick();
  endtask

  task automatic test_store_store();
    idleInputs();
    memWrite1 = 1; addr1 = 10'd9; writeData1 = 32'h01;
    memWrite2 = 1; addr2 = 10'd9; writeData2 = 32'h02;
    #1;
    vectors++;
    if (dmemWE !== 1'b1 || dmemWriteData !== 32'h01 || stallMem !== 1'b1) begin
      miscompares++; $display("FAIL ss_c0 got we=%0b wd=%h stall=%0b want we=1 wd=01 stall=1", dmemWE, dmemWriteData, stallMem);
    end
    tick();
    vectors++;
    if (dmemWE !== 1'b1 || dmemWriteData !== 32'h02 || stallMem !== 1'b0) begin
      miscompares++; $display("FAIL ss_c1 got we=%0b wd=%h stall=%0b want we=1 wd=02 stall=0", dmemWE, dmemWriteData, stallMem);
    end
    tick();
    idleInputs();
    #1;
    vectors++;
    if (mem[9] !== 32'h02) begin miscompares++; $display("FAIL ss_mem got %h want 02", mem[9]); end
    $display("store/store addr9: mem=%h", mem[9]);
  endtask

  task automatic test_kill_second();
    idleInputs();
    memRead1  = 1; addr1 = 10'd10;
    memWrite2 = 1; addr2 = 10'd11; writeData2 = 32'h99;
    #1;
    vectors++;
    if (stallMem !== 1'b1) begin miscompares++; $display("FAIL ks_c0 got stall=%0b want 1", stallMem); end
    tick();
    killMem2 = 1;
    #1;
    vectors++;
    if (dmemWE !== 1'b0 || stallMem !== 1'b0 || readData1 !== 32'h5A) begin
      miscompares++; $display("FAIL ks_c1 got we=%0b stall=%0b rd1=%h want we=0 stall=0 rd1=5a", dmemWE, stallMem, readData1);
    end
    tick();
    idleInputs();
    #1;
    vectors++;
    if (mem[11] !== 32'h33) begin miscompares++; $display("FAIL ks_mem got %h want 33", mem[11]); end
    // A fresh conflict stalls only if the FSM is back in IDLE.
    memRead1 = 1; addr1 = 10'd3;
    memRead2 = 1; addr2 = 10'd7;
    #1;
    vectors++;
    if (stallMem !== 1'b1) begin miscompares++; $display("FAIL ks_idle got stall=%0b want 1", stallMem); end
    $display("kill in SECOND: mem[11]=%h", mem[11]);
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_merge();
    idleInputs();
    memRead1 = 1; addr1 = 10'd6;
    memRead2 = 1; addr2 = 10'd6;
    #1;
`ifdef DMEM_ARB_LOAD_MERGE_EN
    vectors++;
    if (stallMem !== 1'b0 || readData1 !== 32'h77 || readData2 !== 32'h77) begin
      miscompares++; $display("FAIL merge got stall=%0b rd1=%h rd2=%h want stall=0 rd1=77 rd2=77", stallMem, readData1, readData2);
    end
    $display("merge loads addr6: rd1=%h rd2=%h", readData1, readData2);
    tick();
`else
    vectors++;
    if (stallMem !== 1'b1) begin miscompares++; $display("FAIL nomerge_c0 got stall=%0b want 1", stallMem); end
    tick();
    vectors++;
    if (stallMem !== 1'b0 || readData1 !== 32'h77 || readData2 !== 32'h77) begin
      miscompares++; $display("FAIL nomerge_c1 got stall=%0b rd1=%h rd2=%h want stall=0 rd1=77 rd2=77", stallMem, readData1, readData2);
    end
    $display("same-addr loads serialized: rd1=%h rd2=%h", readData1, readData2);
`endif
    idleInputs();
    tick();
  endtask

  task automatic test_reset_in_second();
    idleInputs();
    memRead1 = 1; addr1 = 10'd3;
    memRead2 = 1; addr2 = 10'd7;
    tick();
    reset = 1;
    #1;
    vectors++;
    if (stallMem !== 1'b0 || dmemAddr !== 10'd7) begin
      miscompares++; $display("FAIL rs_second got stall=%0b addr=%0d want stall=0 addr=7", stallMem, dmemAddr);
    end
    tick();
    reset = 0;
    idleInputs();
    #1;
    vectors++;
    if (stallMem !== 1'b0 || dmemWE !== 1'b0) begin
      miscompares++; $display("FAIL rs_idle got stall=%0b we=%0b want 0 0", stallMem, dmemWE);
    end
    vectors++;
    if (dut.hold1Reg !== 32'h0) begin miscompares++; $display("FAIL rs_hold got %h want 0", dut.hold1Reg); end
    $display("reset in SECOND: stall=%0b hold1=%h", stallMem, dut.hold1Reg);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_lane1();
    test_single_lane2();
    test_conflict_loads();
    test_store_then_load();
    test_store_store();
    test_kill_second();
    test_merge();
    test_reset_in_second();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dmem_port_arbiter
